// File: rtl/sfp_acc.sv
// sfp_acc: per-lane saturating accumulator bank with registered,
// optionally ReLU'd read-back toward the psum memory.
//
// Ports:
//   clk, reset           : clock, async active-high reset
//   acc, first, wr_addr  : accumulate strobe, overwrite qualifier, entry
//   in_data              : col lanes of signed psum_bw, lane i at [i*psum_bw +: psum_bw]
//   rd, rd_addr, relu    : read strobe, entry, clamp-negatives-to-zero
//   sfp_out, out_valid   : registered read data and its one-cycle strobe
//   ovf                  : sticky, any lane saturated since reset
module sfp_acc #(
  parameter int col     = 16,
  parameter int psum_bw = 16,
  parameter int depth   = 16,
  localparam int AW     = $clog2(depth),
  localparam int W      = col * psum_bw
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          acc,
  input  logic          first,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  in_data,
  input  logic          rd,
  input  logic [AW-1:0] rd_addr,
  input  logic          relu,
  output logic [W-1:0]  sfp_out,
  output logic          out_valid,
  output logic          ovf
);

  localparam logic [psum_bw-1:0] MAXV = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] MINV = {1'b1, {(psum_bw-1){1'b0}}};

  logic [W-1:0] mem_q [depth];
  logic [W-1:0] wdata_d;
  logic [W-1:0] rdata_d;
  logic [W-1:0] sfp_out_q;
  logic         out_valid_q;
  logic         ovf_q;
  logic         ovf_d;
  logic [col-1:0] lane_sat;

  for (genvar i = 0; i < col; i++) begin : g_lane
    logic [psum_bw-1:0] old_l;
    logic [psum_bw-1:0] in_l;
    logic [psum_bw-1:0] rd_l;
    logic [psum_bw:0]   sum;
    logic               pos_o;
    logic               neg_o;

    assign old_l = mem_q[wr_addr][i*psum_bw +: psum_bw];
    assign in_l  = in_data[i*psum_bw +: psum_bw];
    // Sign-extend both operands by one bit; the top two bits
    // of the sum disagree exactly when the result leaves range.
    assign sum   = {old_l[psum_bw-1], old_l}
                 + {in_l[psum_bw-1], in_l};
    assign pos_o = ~sum[psum_bw] & sum[psum_bw-1];
    assign neg_o = sum[psum_bw] & ~sum[psum_bw-1];
    assign lane_sat[i] = pos_o | neg_o;

    assign wdata_d[i*psum_bw +: psum_bw] =
      first ? in_l :
      pos_o ? MAXV :
      neg_o ? MINV :
              sum[psum_bw-1:0];

    assign rd_l = mem_q[rd_addr][i*psum_bw +: psum_bw];
    assign rdata_d[i*psum_bw +: psum_bw] =
      (relu & rd_l[psum_bw-1]) ? '0 : rd_l;
  end

  assign ovf_d = ovf_q | (acc & ~first & (|lane_sat));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < depth; a++) begin
        mem_q[a] <= '0;
      end
    end else if (acc) begin
      mem_q[wr_addr] <= wdata_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sfp_out_q   <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= rd;
      ovf_q       <= ovf_d;
      if (rd) begin
        sfp_out_q <= rdata_d;
      end
    end
  end

  assign sfp_out   = sfp_out_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule
